// File: rtl/as_src_mac_bind_check_pkg.sv
// Shared constants for the source-MAC anti-spoof stage: FSM encodings, MAC field layout and the
// helper that spots addresses which can never be legitimate sources.
package as_src_mac_bind_check_pkg;

  localparam int unsigned MacWidth = 48;
  localparam int unsigned McastBit = 40;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSearch = 2'd1;
  localparam logic [1:0] StLearn  = 2'd2;
  localparam logic [1:0] StResult = 2'd3;

  // Group or all-zero addresses are rejected without a table search.
  function automatic logic mac_is_reserved(input logic [MacWidth-1:0] mac);
    return mac[McastBit] || (mac == '0);
  endfunction

endpackage

// File: rtl/as_mac_bind_table.sv
// Register array of {valid, mac, port} bindings: one combinational read port, one write port and
// a clear-all that invalidates every entry (clear takes priority over a write).
module as_mac_bind_table
  import as_src_mac_bind_check_pkg::*;
#(
  parameter int unsigned NUM_IQ_BITS    = 3,
  parameter int unsigned NUM_ENTRIES    = 16,
  parameter int unsigned ENTRY_IDX_BITS = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clear_i,
  input  logic [ENTRY_IDX_BITS-1:0] rd_idx_i,
  output logic                      rd_valid_o,
  output logic [MacWidth-1:0]       rd_mac_o,
  output logic [NUM_IQ_BITS-1:0]    rd_port_o,
  input  logic                      wr_en_i,
  input  logic [ENTRY_IDX_BITS-1:0] wr_idx_i,
  input  logic [MacWidth-1:0]       wr_mac_i,
  input  logic [NUM_IQ_BITS-1:0]    wr_port_i
);

  logic [NUM_ENTRIES-1:0] valid_q;
  logic [MacWidth-1:0]    mac_q  [NUM_ENTRIES];
  logic [NUM_IQ_BITS-1:0] port_q [NUM_ENTRIES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
        mac_q[i]  <= '0;
        port_q[i] <= '0;
      end
    end else if (clear_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
      mac_q[wr_idx_i]   <= wr_mac_i;
      port_q[wr_idx_i]  <= wr_port_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_mac_o   = mac_q[rd_idx_i];
  assign rd_port_o  = port_q[rd_idx_i];

endmodule

// File: rtl/as_src_mac_bind_check.sv
// Anti-spoof check: binds each source MAC to its ingress port, scanning the table one entry per
// cycle, and hands one pass/learned/spoof verdict per packet to the consumer via vld/rd.
module as_src_mac_bind_check
  import as_src_mac_bind_check_pkg::*;
#(
  parameter int unsigned NUM_IQ_BITS    = 3,
  parameter int unsigned NUM_ENTRIES    = 16,
  parameter int unsigned ENTRY_IDX_BITS = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [MacWidth-1:0]    src_mac,
  input  logic [NUM_IQ_BITS-1:0] src_port,
  input  logic                   eth_done,
  input  logic                   table_clear,
  output logic                   chk_vld,
  output logic                   chk_spoof,
  output logic                   chk_learned,
  input  logic                   chk_rd,
  output logic                   chk_overrun,
  output logic [31:0]            spoof_count
);

  localparam logic [ENTRY_IDX_BITS-1:0] LastIdx = ENTRY_IDX_BITS'(NUM_ENTRIES - 1);

  logic [1:0]                state_q, state_d;
  logic [ENTRY_IDX_BITS-1:0] idx_q, idx_d;
  logic [MacWidth-1:0]       mac_q, mac_d;
  logic [NUM_IQ_BITS-1:0]    port_q, port_d;
  logic                      free_found_q, free_found_d;
  logic [ENTRY_IDX_BITS-1:0] free_idx_q, free_idx_d;
  logic [ENTRY_IDX_BITS-1:0] victim_q, victim_d;
  logic                      eth_done_q;
  logic                      vld_q, vld_d, spoof_q, spoof_d, learned_q, learned_d;
  logic                      overrun_q;
  logic [31:0]               spoof_count_q;

  logic                      req, hit, spoof_inc;
  logic                      rd_valid;
  logic [MacWidth-1:0]       rd_mac;
  logic [NUM_IQ_BITS-1:0]    rd_port;
  logic                      wr_en;
  logic [ENTRY_IDX_BITS-1:0] wr_idx;

  assign req = eth_done && !eth_done_q;
  assign hit = rd_valid && (rd_mac == mac_q);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    mac_d        = mac_q;
    port_d       = port_q;
    free_found_d = free_found_q;
    free_idx_d   = free_idx_q;
    victim_d     = victim_q;
    vld_d        = vld_q;
    spoof_d      = spoof_q;
    learned_d    = learned_q;
    wr_en        = 1'b0;
    wr_idx       = free_idx_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          mac_d        = src_mac;
          port_d       = src_port;
          idx_d        = '0;
          free_found_d = 1'b0;
          if (mac_is_reserved(src_mac)) begin
            state_d   = StResult;
            vld_d     = 1'b1;
            spoof_d   = 1'b1;
            learned_d = 1'b0;
          end else begin
            state_d = StSearch;
          end
        end
      end
      StSearch: begin
        if (table_clear) begin
          state_d = StIdle;
        end else if (hit) begin
          state_d   = StResult;
          vld_d     = 1'b1;
          spoof_d   = (rd_port != port_q);
          learned_d = 1'b0;
        end else begin
          if (!rd_valid && !free_found_q) begin
            free_found_d = 1'b1;
            free_idx_d   = idx_q;
          end
          if (idx_q == LastIdx) state_d = StLearn;
          else                  idx_d   = idx_q + 1'b1;
        end
      end
      StLearn: begin
        if (table_clear) begin
          state_d = StIdle;
        end else begin
          wr_en = 1'b1;
          if (!free_found_q) begin
            wr_idx   = victim_q;
            victim_d = victim_q + 1'b1;
          end
          state_d   = StResult;
          vld_d     = 1'b1;
          spoof_d   = 1'b0;
          learned_d = 1'b1;
        end
      end
      StResult: begin
        if (chk_rd) begin
          state_d   = StIdle;
          vld_d     = 1'b0;
          spoof_d   = 1'b0;
          learned_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (table_clear) victim_d = '0;
  end

  assign spoof_inc = spoof_d && (state_d == StResult) && (state_q != StResult);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      mac_q         <= '0;
      port_q        <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      victim_q      <= '0;
      eth_done_q    <= 1'b0;
      vld_q         <= 1'b0;
      spoof_q       <= 1'b0;
      learned_q     <= 1'b0;
      overrun_q     <= 1'b0;
      spoof_count_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      mac_q        <= mac_d;
      port_q       <= port_d;
      free_found_q <= free_found_d;
      free_idx_q   <= free_idx_d;
      victim_q     <= victim_d;
      eth_done_q   <= eth_done;
      vld_q        <= vld_d;
      spoof_q      <= spoof_d;
      learned_q    <= learned_d;
      overrun_q    <= req && (state_q != StIdle);
      if (spoof_inc && (spoof_count_q != 32'hFFFF_FFFF)) spoof_count_q <= spoof_count_q + 1'b1;
    end
  end

  as_mac_bind_table #(
    .NUM_IQ_BITS   (NUM_IQ_BITS),
    .NUM_ENTRIES   (NUM_ENTRIES),
    .ENTRY_IDX_BITS(ENTRY_IDX_BITS)
  ) u_table (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_i   (table_clear),
    .rd_idx_i  (idx_q),
    .rd_valid_o(rd_valid),
    .rd_mac_o  (rd_mac),
    .rd_port_o (rd_port),
    .wr_en_i   (wr_en),
    .wr_idx_i  (wr_idx),
    .wr_mac_i  (mac_q),
    .wr_port_i (port_q)
  );

  assign chk_vld     = vld_q;
  assign chk_spoof   = spoof_q;
  assign chk_learned = learned_q;
  assign chk_overrun = overrun_q;
  assign spoof_count = spoof_count_q;

endmodule

// File: tb/tb_as_src_mac_bind_check.sv
// Bench for as_src_mac_bind_check: directed vector table, hand-written corner sequences and
// random traffic checked against a reference binding table kept in the bench.
module tb_as_src_mac_bind_check;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [47:0] src_mac = '0;
  logic [2:0]  src_port = '0;
  logic        eth_done = 1'b0;
  logic        table_clear = 1'b0;
  logic        chk_rd = 1'b0;
  logic        chk_vld, chk_spoof, chk_learned, chk_overrun;
  logic [31:0] spoof_count;

  always #5 clk = ~clk;

  as_src_mac_bind_check dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .src_mac    (src_mac),
    .src_port   (src_port),
    .eth_done   (eth_done),
    .table_clear(table_clear),
    .chk_vld    (chk_vld),
    .chk_spoof  (chk_spoof),
    .chk_learned(chk_learned),
    .chk_rd     (chk_rd),
    .chk_overrun(chk_overrun),
    .spoof_count(spoof_count)
  );

  int n_checks = 0;
  int n_fail = 0;
  int ovr_cnt = 0;
  int vld_rises = 0;
  logic vld_prev = 1'b0;

  always @(negedge clk) begin
    if (chk_overrun) ovr_cnt++;
    if (chk_vld && !vld_prev) vld_rises++;
    vld_prev = chk_vld;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference model: the binding table as plain arrays.
  bit          m_valid [16];
  logic [47:0] m_mac   [16];
  logic [2:0]  m_port  [16];
  int          m_victim;
  int          m_spoofs;

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 0;
    m_victim = 0;
  endtask

  task automatic model_req(input logic [47:0] mac, input logic [2:0] port,
                           output bit spoof, output bit learned, output int lat);
    int hit_i, free_i;
    hit_i = -1;
    free_i = -1;
    if (mac[40] || mac == 48'h0) begin
      spoof = 1; learned = 0; lat = 1;
    end else begin
      for (int i = 0; i < 16; i++) if (hit_i < 0 && m_valid[i] && m_mac[i] == mac) hit_i = i;
      if (hit_i >= 0) begin
        spoof = (m_port[hit_i] != port); learned = 0; lat = hit_i + 2;
      end else begin
        for (int i = 0; i < 16; i++) if (free_i < 0 && !m_valid[i]) free_i = i;
        if (free_i < 0) begin
          free_i = m_victim;
          m_victim = (m_victim + 1) % 16;
        end
        m_valid[free_i] = 1; m_mac[free_i] = mac; m_port[free_i] = port;
        spoof = 0; learned = 1; lat = 18;
      end
    end
    if (spoof) m_spoofs++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; eth_done = 1'b0; chk_rd = 1'b0; table_clear = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    m_spoofs = 0;
  endtask

  // Raise eth_done, wait (bounded) for the verdict, then consume it.
  task automatic run_req(input logic [47:0] mac, input logic [2:0] port, input bit clr,
                         output bit spoof, output bit learned, output int lat);
    @(negedge clk);
    src_mac = mac; src_port = port; eth_done = 1'b1; table_clear = clr;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      table_clear = 1'b0;
      lat++;
      if (chk_vld) break;
    end
    if (!chk_vld) lat = 99;
    spoof = chk_spoof;
    learned = chk_learned;
    @(negedge clk);
    chk_rd = 1'b1; eth_done = 1'b0;
    @(negedge clk);
    chk_rd = 1'b0;
  endtask

  task automatic req_and_check(input string name, input logic [47:0] mac, input logic [2:0] port,
                               input bit clr, output int got_lat);
    bit e_sp, e_ln, g_sp, g_ln;
    int e_lat;
    if (clr) model_clear();
    model_req(mac, port, e_sp, e_ln, e_lat);
    run_req(mac, port, clr, g_sp, g_ln, got_lat);
    check({name, "_lat"}, got_lat, e_lat);
    check({name, "_spoof"}, g_sp, e_sp);
    check({name, "_learned"}, g_ln, e_ln);
    check({name, "_count"}, spoof_count, m_spoofs);
    check({name, "_vld_cleared"}, chk_vld, 0);
  endtask

  typedef struct {
    logic [47:0] mac;
    logic [2:0]  port;
    bit          spoof;
    bit          learned;
    int          lat;
    int          count;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit g_sp, g_ln, d_sp, d_ln;
    int g_lat, d_lat, v0, o0, bad;
    logic [47:0] mac;
    logic [2:0] port;

    vecs[0] = '{48'h0011_2233_4455, 3'd2, 0, 1, 18, 0};
    vecs[1] = '{48'h0011_2233_4455, 3'd2, 0, 0, 2, 0};
    vecs[2] = '{48'h0011_2233_4455, 3'd5, 1, 0, 2, 1};
    vecs[3] = '{48'h0011_2233_4455, 3'd2, 0, 0, 2, 1};
    vecs[4] = '{48'h0100_5E00_0001, 3'd0, 1, 0, 1, 2};
    vecs[5] = '{48'h0000_0000_0000, 3'd0, 1, 0, 1, 3};

    model_clear();
    m_spoofs = 0;
    repeat (2) @(negedge clk);
    check("rst_vld", chk_vld, 0);
    check("rst_spoof", chk_spoof, 0);
    check("rst_learned", chk_learned, 0);
    check("rst_overrun", chk_overrun, 0);
    check("rst_count", spoof_count, 0);
    reset_n = 1'b1;

    // Directed vectors: learn, pass, spoof, entry unchanged, multicast, zero MAC.
    for (int i = 0; i < 6; i++) begin
      model_req(vecs[i].mac, vecs[i].port, d_sp, d_ln, d_lat);
      run_req(vecs[i].mac, vecs[i].port, 0, g_sp, g_ln, g_lat);
      check($sformatf("vec%0d_lat", i), g_lat, vecs[i].lat);
      check($sformatf("vec%0d_spoof", i), g_sp, vecs[i].spoof);
      check($sformatf("vec%0d_learned", i), g_ln, vecs[i].learned);
      check($sformatf("vec%0d_count", i), spoof_count, vecs[i].count);
    end

    // Second request edge during SEARCH is dropped; the verdict is held while chk_rd stays low.
    v0 = vld_rises; o0 = ovr_cnt;
    model_req(48'h0022_0000_0001, 3'd1, d_sp, d_ln, d_lat);
    @(negedge clk);
    src_mac = 48'h0022_0000_0001; src_port = 3'd1; eth_done = 1'b1;
    repeat (3) @(negedge clk);
    eth_done = 1'b0;
    @(negedge clk);
    eth_done = 1'b1;
    for (int c = 0; c < 40 && !chk_vld; c++) @(negedge clk);
    check("ovr_vld", chk_vld, 1);
    check("ovr_pulses", ovr_cnt - o0, 1);
    check("ovr_learned", chk_learned, d_ln);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!chk_vld || chk_learned !== d_ln || chk_spoof !== d_sp) bad++;
    end
    check("hold_stable", bad, 0);
    chk_rd = 1'b1; eth_done = 1'b0;
    @(negedge clk);
    chk_rd = 1'b0;
    repeat (20) @(negedge clk);
    check("ovr_one_verdict", vld_rises - v0, 1);
    check("ovr_count", spoof_count, m_spoofs);

    // table_clear mid-SEARCH: no verdict, then the old MAC is learned afresh.
    v0 = vld_rises;
    @(negedge clk);
    src_mac = 48'h0033_0000_0002; src_port = 3'd3; eth_done = 1'b1;
    repeat (5) @(negedge clk);
    table_clear = 1'b1;
    @(negedge clk);
    table_clear = 1'b0; eth_done = 1'b0;
    repeat (25) @(negedge clk);
    check("clr_no_verdict", vld_rises - v0, 0);
    model_clear();
    req_and_check("clr_relearn", 48'h0011_2233_4455, 3'd2, 0, g_lat);
    check("clr_relearn_idx0", g_lat, 18);
    req_and_check("clr_hit", 48'h0011_2233_4455, 3'd2, 0, g_lat);

    // Clear coincident with a request in IDLE: processed against an empty table.
    req_and_check("clr_coincident", 48'h0011_2233_4455, 3'd2, 1, g_lat);

    // Asynchronous reset while a verdict is held.
    @(negedge clk);
    src_mac = 48'h0011_2233_4455; src_port = 3'd2; eth_done = 1'b1;
    for (int c = 0; c < 40 && !chk_vld; c++) @(negedge clk);
    check("rst_mid_pre_vld", chk_vld, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_vld", chk_vld, 0);
    check("rst_mid_count", spoof_count, 0);
    @(negedge clk);
    eth_done = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    m_spoofs = 0;
    req_and_check("rst_table_lost", 48'h0011_2233_4455, 3'd2, 0, g_lat);

    // Table full: 17th MAC evicts idx 0, first MAC then relearned at idx 1.
    do_reset();
    for (int i = 1; i <= 17; i++)
      req_and_check($sformatf("full%0d", i), 48'h0200_0000_0000 | 48'(i), 3'(i), 0, g_lat);
    req_and_check("full_first_miss", 48'h0200_0000_0001, 3'd1, 0, g_lat);
    check("full_first_relearn", g_lat, 18);
    req_and_check("full_17_at_idx0", 48'h0200_0000_0011, 3'd1, 0, g_lat);
    check("full_17_lat", g_lat, 2);
    req_and_check("full_first_at_idx1", 48'h0200_0000_0001, 3'd1, 0, g_lat);
    check("full_first_lat", g_lat, 3);

    // Random traffic over a pool larger than the table.
    do_reset();
    for (int i = 0; i < 60; i++) begin
      int r, k;
      r = int'($urandom_range(0, 99));
      k = int'($urandom_range(0, 19));
      if (r < 5)       mac = 48'h0100_5E00_0000 | 48'(r);
      else if (r < 8)  mac = 48'h0;
      else             mac = 48'h0000_1000_0000 + 48'(k * 257 + 1);
      port = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'(k % 8);
      req_and_check($sformatf("rnd%0d", i), mac, port, 0, g_lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
